// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole switch allocator: round-robin grant held for a whole
// packet, one-hot pops toward the owner input, and credit tracking for the downstream buffer.
module noc_output_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int CREDITS   = 5,
    parameter int CW        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    valid_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS*16-1:0] data_i,
    input  logic                    credit_i,
    output logic [NUM_PORTS-1:0]    shift_o,
    output logic [15:0]             data_o,
    output logic                    out_valid_o,
    output logic                    credit_err_o
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        credits_q, credits_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [IW-1:0]        winner;
    logic [IW-1:0]        cand;
    logic                 found;
    logic                 send;
    logic [15:0]          flit [NUM_PORTS];
    logic [15:0]          owner_flit;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flit
        assign flit[g] = data_i[16*g +: 16];
    end

    assign owner_flit = flit[owner_q];

    // Descending scan so the last hit is the nearest eligible port after ptr.
    always_comb begin
        eligible = valid_i & req_i;
        winner   = ptr_q;
        cand     = ptr_q;
        found    = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = IW'((int'(ptr_q) + k) % NUM_PORTS);
            if (eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign send = (state_q == LOCKED) && valid_i[owner_q] && (credits_q != '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (send && owner_flit[14]) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop and a returned credit in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (send && !credit_i) begin
            credits_d = credits_q - CW'(1);
        end else if (credit_i && !send) begin
            if (credits_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= IW'(NUM_PORTS - 1);
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign shift_o      = send ? (NUM_PORTS'(1) << owner_q) : '0;
    assign out_valid_o  = send;
    assign data_o       = (state_q == LOCKED) ? owner_flit : 16'h0000;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios against fixed
// expectations plus randomized traffic against a packet-level reference model.
module tb_noc_output_arbiter;
    localparam int NP = 5;
    localparam int CR = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    valid_i, req_i, shift_o;
    logic [NP*16-1:0] data_i;
    logic             credit_i, out_valid_o, credit_err_o;
    logic [15:0]      data_o;

    int checks = 0;
    int errors = 0;

    noc_output_arbiter #(.NUM_PORTS(NP), .CREDITS(CR), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .req_i        (req_i),
        .data_i       (data_i),
        .credit_i     (credit_i),
        .shift_o      (shift_o),
        .data_o       (data_o),
        .out_valid_o  (out_valid_o),
        .credit_err_o (credit_err_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        valid_i  = '0;
        req_i    = '0;
        data_i   = '0;
        credit_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_flit(input int p, input logic [15:0] v);
        data_i[p*16 +: 16] = v;
    endtask

    function automatic logic [15:0] stall_flit(input int idx);
        if (idx == 0) return 16'h8000;
        if (idx == 6) return 16'h4006;
        return 16'(idx);
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (shift_o !== '0) begin errors++; $display("[TB] FAIL reset_shift: got %b, expected 00000", shift_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid_o); end
        checks++; if (data_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0000", data_o); end
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0", credit_err_o); end
    endtask

    task automatic test_single_packet();
        logic [15:0] fl [3];
        fl[0] = 16'h8000; fl[1] = 16'h0001; fl[2] = 16'h4002;
        do_reset();
        valid_i[2] = 1'b1; req_i[2] = 1'b1; set_flit(2, fl[0]);
        #1;
        checks++; if (out_valid_o !== 1'b0 || shift_o !== '0) begin errors++; $display("[TB] FAIL single_idle: got valid=%b shift=%b, expected 0/00000", out_valid_o, shift_o); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_flit(2, fl[i]);
            req_i[2] = (i == 0);
            #1;
            checks++; if (shift_o !== 5'b00100) begin errors++; $display("[TB] FAIL single_shift%0d: got %b, expected 00100", i, shift_o); end
            checks++; if (data_o !== fl[i]) begin errors++; $display("[TB] FAIL single_data%0d: got %h, expected %h", i, data_o, fl[i]); end
            @(negedge clk);
        end
        valid_i = '0; req_i = '0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || data_o !== 16'h0) begin errors++; $display("[TB] FAIL single_back_idle: got valid=%b data=%h, expected 0/0000", out_valid_o, data_o); end
        // Two credits remain: a second 3-flit packet must stall on its tail.
        @(negedge clk);
        valid_i[2] = 1'b1; req_i[2] = 1'b1; set_flit(2, fl[0]);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_flit(2, fl[i]);
            req_i[2] = 1'b0;
            #1;
            checks++; if (out_valid_o !== (i < 2)) begin errors++; $display("[TB] FAIL single_credits_left%0d: got %b, expected %b", i, out_valid_o, (i < 2)); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp [8];
        exp = '{5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b00000, 5'b00001, 5'b00000, 5'b01000};
        do_reset();
        valid_i = 5'b01001; req_i = 5'b01001;
        set_flit(0, 16'hC000); set_flit(3, 16'hC000);
        for (int i = 0; i < 8; i++) begin
            credit_i = (i > 0) && (exp[i-1] != '0);
            #1;
            checks++; if (shift_o !== exp[i]) begin errors++; $display("[TB] FAIL rr_shift%0d: got %b, expected %b", i, shift_o, exp[i]); end
            checks++; if (out_valid_o !== (exp[i] != '0)) begin errors++; $display("[TB] FAIL rr_valid%0d: got %b, expected %b", i, out_valid_o, (exp[i] != '0)); end
            @(negedge clk);
        end
        credit_i = 1'b0;
        #1;
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rr_err: got %b, expected 0", credit_err_o); end
    endtask

    task automatic test_credit_stall();
        logic [12:0] expv;
        int idx;
        expv = 13'b0101000111110;
        idx  = 0;
        do_reset();
        valid_i[1] = 1'b1; req_i[1] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            set_flit(1, stall_flit(idx));
            valid_i[1] = (idx < 7);
            req_i[1]   = (idx == 0);
            credit_i   = (i == 8) || (i == 10);
            #1;
            checks++; if (out_valid_o !== expv[i]) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b, expected %b", i, out_valid_o, expv[i]); end
            if (expv[i]) begin
                checks++; if (data_o !== stall_flit(idx) || shift_o !== 5'b00010) begin errors++; $display("[TB] FAIL stall_flit%0d: got data=%h shift=%b, expected %h/00010", i, data_o, shift_o, stall_flit(idx)); end
                idx++;
            end
            if (i == 12) begin
                checks++; if (data_o !== 16'h0) begin errors++; $display("[TB] FAIL stall_idle_data: got %h, expected 0000", data_o); end
            end
            @(negedge clk);
        end
        credit_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] expv;
        expv = 8'b01111110;
        do_reset();
        valid_i[4] = 1'b1; req_i[4] = 1'b1; set_flit(4, 16'h8000);
        for (int i = 0; i < 8; i++) begin
            credit_i = (i == 3);
            #1;
            checks++; if (out_valid_o !== expv[i]) begin errors++; $display("[TB] FAIL simul_valid%0d: got %b, expected %b", i, out_valid_o, expv[i]); end
            @(negedge clk);
        end
        credit_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        credit_i = 1'b1;
        #1;
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before: got %b, expected 0", credit_err_o); end
        @(negedge clk);
        credit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (credit_err_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky%0d: got %b, expected 1", i, credit_err_o); end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b, expected 0", credit_err_o); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        valid_i[0] = 1'b1; req_i[0] = 1'b1; set_flit(0, 16'hC000);
        repeat (2) @(negedge clk);
        valid_i[0] = 1'b0; req_i[0] = 1'b0;
        valid_i[3] = 1'b1; req_i[3] = 1'b1; set_flit(3, 16'h8000);
        @(negedge clk);
        #1;
        checks++; if (shift_o !== 5'b01000) begin errors++; $display("[TB] FAIL mid_first: got %b, expected 01000", shift_o); end
        @(negedge clk);
        set_flit(3, 16'h0001); req_i[3] = 1'b0; rst = 1'b1;
        #1;
        checks++; if (shift_o !== 5'b01000) begin errors++; $display("[TB] FAIL mid_second: got %b, expected 01000", shift_o); end
        @(negedge clk);
        rst = 1'b0;
        valid_i[0] = 1'b1; req_i[0] = 1'b1; set_flit(0, 16'h8000);
        req_i[3] = 1'b1;
        #1;
        checks++; if (shift_o !== '0 || out_valid_o !== 1'b0 || data_o !== 16'h0) begin errors++; $display("[TB] FAIL mid_idle: got shift=%b valid=%b data=%h, expected 00000/0/0000", shift_o, out_valid_o, data_o); end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (shift_o !== ((i < 5) ? 5'b00001 : 5'b00000)) begin errors++; $display("[TB] FAIL mid_restart%0d: got %b, expected %b", i, shift_o, ((i < 5) ? 5'b00001 : 5'b00000)); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int          holder, last, cred;
        logic        merr, msend, found;
        logic [15:0] hf, v;
        logic [NP-1:0] eshift;
        do_reset();
        holder = -1; last = NP - 1; cred = CR; merr = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_i = NP'($urandom);
            req_i   = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                v = 16'($urandom);
                v[14] = ($urandom_range(0, 2) == 0);
                set_flit(p, v);
            end
            credit_i = ((cred < CR) && ($urandom_range(0, 9) < 4)) || ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            hf     = (holder >= 0) ? data_i[holder*16 +: 16] : 16'h0;
            msend  = (holder >= 0) && valid_i[holder] && (cred > 0);
            eshift = msend ? NP'(1 << holder) : '0;
            checks++; if (shift_o !== eshift) begin errors++; $display("[TB] FAIL rand_shift@%0d: got %b, expected %b", cyc, shift_o, eshift); end
            checks++; if (out_valid_o !== msend) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b, expected %b", cyc, out_valid_o, msend); end
            checks++; if (data_o !== hf) begin errors++; $display("[TB] FAIL rand_data@%0d: got %h, expected %h", cyc, data_o, hf); end
            checks++; if (credit_err_o !== merr) begin errors++; $display("[TB] FAIL rand_err@%0d: got %b, expected %b", cyc, credit_err_o, merr); end
            if (rst) begin
                holder = -1; last = NP - 1; cred = CR; merr = 1'b0;
            end else begin
                if (credit_i && !msend) begin
                    if (cred == CR) merr = 1'b1;
                    else cred++;
                end else if (msend && !credit_i) begin
                    cred--;
                end
                if (holder < 0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        int p;
                        p = (last + k) % NP;
                        if (!found && valid_i[p] && req_i[p]) begin
                            holder = p;
                            found  = 1'b1;
                        end
                    end
                end else if (msend && hf[14]) begin
                    last   = holder;
                    holder = -1;
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_stall();
        test_simultaneous();
        test_overflow();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Per-output-port switch allocator for the NoC router. It picks one of the router's input ports whose head flit is routed to this output, using round-robin arbitration, and holds that grant for the whole packet (wormhole). It pops the winner's input buffer with one-hot `shift` pulses and steers its flits to the output link. It also tracks credits for the downstream input buffer, so a flit is only sent when the downstream side has space.

## Interface
Parameters:
- `NUM_PORTS`, default 5: number of requesting input ports (N, E, S, W, Local).
- `CREDITS`, default 5: depth of the downstream input buffer, which is also the initial credit count.
- `CW`, default 3: credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid_i`, input, NUM_PORTS: `read_valid_o` of each input port (its buffer is non-empty).
- `req_i`, input, NUM_PORTS: the head flit of port i is routed to this output (from route compute).
- `data_i`, input, NUM_PORTS*16: head flit of each input port; port i occupies bits [16i+15:16i].
- `credit_i`, input, 1: one-cycle pulse; downstream popped one flit.
- `shift_o`, output, NUM_PORTS: one-hot pop strobe to the owner input port's `shift`.
- `data_o`, output, 16: flit sent to the output link, which is `data_i` of the owner port.
- `out_valid_o`, output, 1: `data_o` is valid and is written downstream this cycle.
- `credit_err_o`, output, 1: sticky flag; `credit_i` arrived while credits were already at CREDITS.

## Operation
Flit format: bit 15 = head, bit 14 = tail. A single-flit packet has both bits set. The remaining bits are ignored by this block.

State machine, two states:
- **IDLE**
  - A port is eligible when `valid_i[i] & req_i[i]`.
  - If any port is eligible, the winner is the first eligible port searching upward from `ptr+1`, mod NUM_PORTS.
  - On a win: latch `owner <= winner` and move to LOCKED.
  - If no port is eligible, stay in IDLE.
  - The credit count does not gate arbitration.
  - `shift_o`=0 and `out_valid_o`=0 throughout IDLE.
- **LOCKED**
  - Define `send = valid_i[owner] & (credits != 0)`.
  - `shift_o = send << owner`; `out_valid_o = send`. Both are combinational.
  - `data_o = data_i[owner]` at all times in LOCKED; it is 0 in IDLE.
  - `req_i` is ignored while LOCKED; only the head flit raises it.
  - On a cycle where `send` is true and `data_i[owner][14]`=1: set `ptr <= owner` and move to IDLE.
  - If `valid_i[owner]` drops mid-packet, stay in LOCKED and wait.

Credits:
- Shift without credit: `credits - 1`.
- Credit without shift: `credits + 1`.
- Shift and credit in the same cycle: unchanged.
- Credit pulse while credits = CREDITS and no shift that cycle: count unchanged; set `credit_err_o`, which holds until `rst`.
- Credits can never underflow, because `send` requires `credits != 0`.

Reset values:
- state = IDLE, `owner` = 0, `ptr` = NUM_PORTS-1 (so port 0 has first priority), credits = CREDITS.
- `credit_err_o` = 0, `shift_o` = 0, `out_valid_o` = 0, `data_o` = 0.

Reset mid-packet: the block returns to IDLE immediately and credits reload. Draining partial packets is the system's problem. Behaviour is undefined unless all routers reset together.

## Timing
- Arbitration latency: eligible in IDLE at cycle t; the first `shift_o` and `out_valid_o` come at t+1 (if a credit is available).
- Throughput: 1 flit/cycle in LOCKED while the owner is valid and credits are nonzero.
- Packet turnaround: tail sent at t, IDLE at t+1, next packet's head sent at t+2. That is exactly one bubble cycle per packet.
- A credit arriving at cycle t can enable a send at t+1. A send does not depend combinationally on `credit_i` in the same cycle.
- `shift_o` is never asserted toward a port with `valid_i`=0, so an input port never sees a pop on an empty buffer.

## Test plan
- **Single packet:** after reset, port 2 presents 3 flits (0x8000, 0x0001, 0x4002) with `req_i[2]`=1 and `valid_i[2]`=1.
  - IDLE 1 cycle, then `shift_o`=00100 for 3 consecutive cycles.
  - `data_o` sequence matches the three flits; back to IDLE.
  - Credits go from 5 to 2.
- **Round-robin:** ports 0 and 3 both request continuously with 1-flit packets (0xC000), with a `credit_i` pulse returned for every send.
  - Grants alternate 0, 3, 0, 3.
  - Each grant is followed by one bubble cycle.
- **Credit stall:** a 7-flit packet with no `credit_i`.
  - 5 flits sent, then `out_valid_o`=0 and credits = 0.
  - A `credit_i` pulse at cycle t gives exactly one send at t+1.
- **Simultaneous credit and shift:** with credits = 3, send and `credit_i` in the same cycle.
  - Credits stay 3.
- **Credit overflow:** `credit_i` pulse while credits = 5 and idle.
  - `credit_err_o` rises the next cycle and stays high until `rst`.
- **Reset mid-packet:** assert `rst` during the second flit of a 4-flit packet.
  - Next cycle: IDLE, `shift_o`=0, credits = 5.
  - Arbitration restarts from port 0.
